riscv_lsu: RTL and testbench
============================

Name: riscv_lsu

Overview:
Parametrised load/store unit that replaces the core's combinational load-extend mux and direct data-memory strobes. It sits between the execute stage and the data memory / MMIO bridge. The unit does the following:
- accepts one access request at a time over a valid/ready handshake
- aligns store data and generates byte enables
- extracts and sign/zero-extends load data
- detects misalignment and bus timeouts
- returns a single-cycle response

Wait-state memories and multi-cycle cores are supported.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
ADDR_W, 32, byte-address width.
TIMEOUT, 255, maximum cycles in REQ without mem_ack before a bus fault; legal range 1..65535.

Ports:
clk  input  1  core clock.
rst  input  1  asynchronous reset, active-high.
req_valid  input  1  core presents an access.
req_ready  output  1  unit can accept; high exactly in IDLE.
req_store  input  1  1=store, 0=load.
req_size  input  2  00=B, 01=H, 10=W, 11=D (D legal only when XLEN=64).
req_unsigned  input  1  zero-extend the load (LBU/LHU/LWU).
req_addr  input  ADDR_W  byte address.
req_wdata  input  XLEN  store data, right-justified.
resp_valid  output  1  one-cycle response pulse.
resp_rdata  output  XLEN  extended load data; 0 for stores and faults.
resp_fault  output  2  00=ok, 01=misaligned/illegal size, 10=bus timeout.
mem_req  output  1  memory request, held until mem_ack.
mem_we  output  1  write strobe.
mem_be  output  XLEN/8  byte enables.
mem_addr  output  ADDR_W  access address, aligned to XLEN/8 bytes.
mem_wdata  output  XLEN  lane-replicated store data.
mem_ack  input  1  memory completion; mem_rdata valid in the same cycle.
mem_rdata  input  XLEN  full-width read data.

Behaviour:
- Reset values (asynchronous, immediate):
  - state IDLE, timeout counter 0
  - mem_req, mem_we, resp_valid = 0
  - mem_be, mem_addr, mem_wdata, resp_rdata, resp_fault = 0
- States: IDLE, REQ, RESP.
- IDLE:
  - req_ready=1. On req_valid, capture store, size, unsigned, addr and wdata.
  - If misaligned or the size is illegal, go to RESP with fault 01; no memory access is made.
  - Otherwise go to REQ.
- Alignment rules, with OFF = addr[log2(XLEN/8)-1:0]:
  - B: any address.
  - H: addr[0]=0.
  - W: addr[1:0]=0.
  - D: addr[2:0]=0.
  - Size 11 with XLEN=32 is an illegal size (fault 01).
- REQ:
  - mem_* outputs are registered on entry and held constant throughout REQ.
  - mem_addr = addr with the OFF bits cleared.
  - mem_be = size mask (B 1, H 3, W 0xF, D 0xFF) shifted left by OFF.
  - mem_wdata = low 8/16/32 bits of wdata replicated across all lanes.
  - mem_we = store.
  - The counter increments each cycle.
  - mem_ack: latch the extracted load data (fault 00) and go to RESP.
  - Counter reaches TIMEOUT: fault 10 and go to RESP.
  - mem_ack takes priority over timeout in the same cycle.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE. mem_req is 0.
  - Load data = mem_rdata shifted right by OFF*8, truncated to the access size.
  - Extension uses that size's own top bit (bit 7 for B, 15 for H, 31 for W), or zero-extends when unsigned.
- Latency: request accepted at cycle N → mem_req high at N+1. mem_ack at cycle N+k → resp_valid at N+k+1 and req_ready at N+k+2. A misaligned request → resp_valid at N+1.
- mem_ack outside REQ is ignored.
- Reset asserted mid-REQ: mem_req drops immediately; no response is issued.
- mem_be never crosses the XLEN/8 boundary, guaranteed by the alignment check.

Decomposition:
- Add to riscv_defs.v: LSU size encodings, fault codes, state encodings.
- One combinational sub-module, riscv_lsu_align: computes be/wdata from (size, OFF, wdata) and extended rdata from (size, unsigned, OFF, mem_rdata). It is shared by the top FSM and reusable by the io bridge.

Test Plan:
1. XLEN=32: LB at addr 0x103 with mem_rdata 0x80FF1234 acked one cycle after mem_req → mem_addr 0x100, mem_be 4'b1000, resp_rdata 0xFFFFFF80 with fault 00. The same access with LBU → 0x00000080.
2. SH at addr 0x102 with wdata 0xABCD1234 → mem_addr 0x100, mem_be 4'b1100, mem_we 1, mem_wdata 0x12341234, resp_rdata 0.
3. LW at addr 0x106 → mem_req never rises, resp_valid at N+1 with fault 01. Size 11 at XLEN=32 → fault 01.
4. TIMEOUT=8, no ack → mem_req high for 8 cycles, then resp_valid with fault 10 and mem_req 0. Repeat with ack on the 8th cycle → fault 00.
5. Assert rst during REQ (ack pending) → mem_req drops immediately, no resp_valid. After release, req_ready=1 and a new LW at 0x200 completes normally.
6. XLEN=64: LD at 0x008 with 3 wait states → mem_be 0xFF. LWU at 0x00C with mem_rdata 0x8765432100000000 → resp_rdata 0x0000000087654321. Back-to-back requests are each accepted exactly one cycle after the prior resp_valid.

Source files
------------

// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: size/fault/state encodings and the alignment rule shared by the load/store unit.
package riscv_lsu_pkg;
  typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_D = 2'b11} lsu_size_e;
  typedef enum logic [1:0] {FLT_OK = 2'b00, FLT_ALIGN = 2'b01, FLT_BUS = 2'b10} lsu_fault_e;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} lsu_state_e;
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lo, input int xlen);
    return size == SZ_D ? (xlen == 32 || lo != 3'b000) :
           size == SZ_W ? lo[1:0] != 2'b00 :
           size == SZ_H ? lo[0] : 1'b0;
  endfunction
endpackage

// File: rtl/riscv_lsu_align.sv
// riscv_lsu_align: byte enables, lane-replicated store data and extended load data.
module riscv_lsu_align
  import riscv_lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [OFF_W-1:0]  off,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN/8-1:0] be,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN-1:0]   ext_rdata
);
  logic [7:0] m;
  logic [XLEN-1:0] sh, mk;
  logic sb;
  always_comb begin
    m = size == SZ_B ? 8'h01 : size == SZ_H ? 8'h03 : size == SZ_W ? 8'h0F : 8'hFF;
    be = (XLEN / 8)'(m << off);
    mem_wdata = size == SZ_B ? {(XLEN / 8){wdata[7:0]}} :
                size == SZ_H ? {(XLEN / 16){wdata[15:0]}} :
                size == SZ_W ? {(XLEN / 32){wdata[31:0]}} : wdata;
    sh = rdata >> {off, 3'b000};
    mk = size == SZ_B ? XLEN'(8'hFF) : size == SZ_H ? XLEN'(16'hFFFF) :
         size == SZ_W ? XLEN'(32'hFFFF_FFFF) : '1;
    // D needs no fill: its mask already covers the whole word
    sb = ~uns & (size == SZ_B ? sh[7] : size == SZ_H ? sh[15] : size == SZ_W ? sh[31] : 1'b0);
    ext_rdata = (sh & mk) | ({XLEN{sb}} & ~mk);
  end
endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: single-outstanding load/store unit between execute and the data memory bus.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ADDR_W = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic [1:0]        resp_fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata
);
  localparam int NB = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  lsu_state_e state, state_n;
  logic [15:0] cnt;
  logic store_q, uns_q, bad, timeout;
  logic [1:0] size_q, a_size;
  logic [OFF_W-1:0] off_q, a_off;
  logic [NB-1:0] a_be;
  logic [XLEN-1:0] a_wdata, a_rdata;
  assign req_ready = state == ST_IDLE;
  assign bad = misaligned(req_size, req_addr[2:0], XLEN);
  assign timeout = cnt == 16'(TIMEOUT - 1);
  // the aligner sees the live request while idle and the captured one afterwards
  assign a_size = req_ready ? req_size : size_q;
  assign a_off = req_ready ? req_addr[OFF_W-1:0] : off_q;
  riscv_lsu_align #(.XLEN(XLEN), .OFF_W(OFF_W)) u_align (
    .size(a_size),
    .uns(uns_q),
    .off(a_off),
    .wdata(req_wdata),
    .rdata(mem_rdata),
    .be(a_be),
    .mem_wdata(a_wdata),
    .ext_rdata(a_rdata)
  );
  always_comb begin
    state_n = state;
    if (state == ST_IDLE && req_valid) state_n = bad ? ST_RESP : ST_REQ;
    else if (state == ST_REQ && (mem_ack || timeout)) state_n = ST_RESP;
    else if (state == ST_RESP) state_n = ST_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      store_q <= 1'b0;
      uns_q <= 1'b0;
      size_q <= '0;
      off_q <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_be <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= FLT_OK;
    end else begin
      resp_valid <= 1'b0;
      if (state == ST_IDLE && req_valid) begin
        store_q <= req_store;
        uns_q <= req_unsigned;
        size_q <= req_size;
        off_q <= req_addr[OFF_W-1:0];
        cnt <= '0;
        if (bad) begin
          resp_valid <= 1'b1;
          resp_fault <= FLT_ALIGN;
          resp_rdata <= '0;
        end else begin
          mem_req <= 1'b1;
          mem_we <= req_store;
          mem_be <= a_be;
          mem_addr <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          mem_wdata <= a_wdata;
        end
      end else if (state == ST_REQ) begin
        if (mem_ack || timeout) begin
          mem_req <= 1'b0;
          mem_we <= 1'b0;
          resp_valid <= 1'b1;
          resp_fault <= mem_ack ? FLT_OK : FLT_BUS;
          resp_rdata <= mem_ack && !store_q ? a_rdata : '0;
        end else cnt <= cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: random and directed accesses on 32- and 64-bit units against a byte-level model.
module tb_riscv_lsu;
  localparam int TO = 8;
  logic clk = 1'b0, rst = 1'b1, sel = 1'b0;
  logic req_valid = 1'b0, req_store = 1'b0, req_unsigned = 1'b0, mem_ack = 1'b0;
  logic [1:0] req_size = '0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0, mem_rdata = '0;
  logic r32, rv32, mr32, we32, r64, rv64, mr64, we64;
  logic [1:0] f32, f64;
  logic [3:0] be32;
  logic [7:0] be64;
  logic [31:0] a32, a64, wd32, rd32;
  logic [63:0] wd64, rd64;
  logic o_ready, o_rv, o_mreq, o_we;
  logic [1:0] o_fault;
  logic [7:0] o_be;
  logic [31:0] o_addr;
  logic [63:0] o_wdata, o_rdata;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  riscv_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TO)) u32 (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(r32),
    .req_store(req_store), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .resp_valid(rv32), .resp_rdata(rd32), .resp_fault(f32),
    .mem_req(mr32), .mem_we(we32), .mem_be(be32), .mem_addr(a32), .mem_wdata(wd32),
    .mem_ack(mem_ack & ~sel), .mem_rdata(mem_rdata[31:0])
  );
  riscv_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT(TO)) u64 (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(r64),
    .req_store(req_store), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv64), .resp_rdata(rd64), .resp_fault(f64),
    .mem_req(mr64), .mem_we(we64), .mem_be(be64), .mem_addr(a64), .mem_wdata(wd64),
    .mem_ack(mem_ack & sel), .mem_rdata(mem_rdata)
  );

  assign o_ready = sel ? r64 : r32;
  assign o_rv = sel ? rv64 : rv32;
  assign o_mreq = sel ? mr64 : mr32;
  assign o_we = sel ? we64 : we32;
  assign o_fault = sel ? f64 : f32;
  assign o_be = sel ? be64 : {4'b0, be32};
  assign o_addr = sel ? a64 : a32;
  assign o_wdata = sel ? wd64 : {32'b0, wd32};
  assign o_rdata = sel ? rd64 : {32'b0, rd32};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_be(input bit x, input logic [1:0] sz, input logic [31:0] a);
    int nb = x ? 8 : 4;
    int off = int'(a % nb);
    logic [7:0] v = '0;
    for (int b = 0; b < (1 << sz); b++) v[off + b] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] exp_wd(input bit x, input logic [1:0] sz, input logic [63:0] wd);
    int n = 1 << sz;
    logic [63:0] v = '0;
    for (int b = 0; b < (x ? 8 : 4); b++) v[8*b +: 8] = wd[8*(b % n) +: 8];
    return v;
  endfunction

  function automatic logic [63:0] exp_ld(input bit x, input logic [1:0] sz, input bit u,
                                         input logic [31:0] a, input logic [63:0] rd);
    int nb = x ? 8 : 4;
    int n = 1 << sz;
    int off = int'(a % nb);
    logic [63:0] v = '0;
    for (int b = 0; b < n; b++) v[8*b +: 8] = rd[8*(off + b) +: 8];
    if (!u && v[8*n-1]) for (int i = 8 * n; i < 8 * nb; i++) v[i] = 1'b1;
    return v;
  endfunction

  // wt = idle REQ cycles before ack; negative means never ack
  task automatic access(input bit x, input logic [1:0] sz, input bit u, input bit st,
                        input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rd,
                        input int wt);
    int n, nb, c, exp_c;
    bit bad, ok;
    nb = x ? 8 : 4;
    n = 1 << sz;
    bad = (sz == 2'b11 && !x) || (a % n != 0);
    ok = wt >= 0 && wt < TO;
    exp_c = ok ? wt + 1 : TO;
    sel = x;
    req_store = st;
    req_size = sz;
    req_unsigned = u;
    req_addr = a;
    req_wdata = wd;
    mem_rdata = rd;
    req_valid = 1'b1;
    #1;
    chk("req_ready", o_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (bad) begin
      chk("bad_mem_req", o_mreq, 0);
      chk("bad_resp_valid", o_rv, 1);
      chk("bad_fault", o_fault, 2'b01);
      chk("bad_rdata", o_rdata, 0);
    end else begin
      chk("mem_req", o_mreq, 1);
      chk("mem_addr", o_addr, a & ~32'(nb - 1));
      chk("mem_be", o_be, exp_be(x, sz, a));
      chk("mem_we", o_we, st);
      chk("mem_wdata", o_wdata, exp_wd(x, sz, wd));
      c = 0;
      do begin
        c++;
        chk("mem_req_held", o_mreq, 1);
        if (wt >= 0 && c == wt + 1) mem_ack = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
      end while (!o_rv && c < 4 * TO);
      chk("req_cycles", c, exp_c);
      chk("resp_valid", o_rv, 1);
      chk("resp_fault", o_fault, ok ? 2'b00 : 2'b10);
      chk("resp_rdata", o_rdata, ok && !st ? exp_ld(x, sz, u, a, rd) : 64'd0);
      chk("mem_req_drop", o_mreq, 0);
    end
    @(posedge clk);
    #1;
    chk("resp_pulse", o_rv, 0);
    chk("ready_again", o_ready, 1);
  endtask

  initial begin
    #1;
    for (int i = 0; i < 2; i++) begin
      sel = i[0];
      #1;
      chk("rst_mem_req", o_mreq, 0);
      chk("rst_mem_we", o_we, 0);
      chk("rst_resp_valid", o_rv, 0);
      chk("rst_mem_be", o_be, 0);
      chk("rst_mem_addr", o_addr, 0);
      chk("rst_mem_wdata", o_wdata, 0);
      chk("rst_resp_rdata", o_rdata, 0);
      chk("rst_resp_fault", o_fault, 0);
    end
    sel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    access(0, 2'b00, 0, 0, 32'h103, 64'd0, 64'h80FF1234, 0);
    access(0, 2'b00, 1, 0, 32'h103, 64'd0, 64'h80FF1234, 0);
    access(0, 2'b01, 0, 1, 32'h102, 64'hABCD1234, 64'd0, 0);
    access(0, 2'b10, 0, 0, 32'h106, 64'd0, 64'd0, 0);
    access(0, 2'b11, 0, 0, 32'h100, 64'd0, 64'd0, 0);
    access(0, 2'b10, 0, 0, 32'h100, 64'd0, 64'h11223344, -1);
    access(0, 2'b10, 0, 0, 32'h104, 64'd0, 64'hCAFEF00D, TO - 1);
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    chk("idle_ack_resp", o_rv, 0);
    chk("idle_ack_ready", o_ready, 1);
    req_size = 2'b10;
    req_store = 1'b0;
    req_addr = 32'h200;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("pre_rst_mem_req", o_mreq, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_drop_mem_req", o_mreq, 0);
    chk("rst_no_resp", o_rv, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_resp", o_rv, 0);
    end
    access(0, 2'b10, 0, 0, 32'h200, 64'd0, 64'h5A5A0001, 1);
    access(1, 2'b11, 0, 0, 32'h008, 64'd0, 64'hF0E1D2C3B4A59687, 3);
    access(1, 2'b10, 1, 0, 32'h00C, 64'd0, 64'h8765432100000000, 0);
    access(1, 2'b10, 0, 0, 32'h00C, 64'd0, 64'h8765432100000000, 0);
    access(1, 2'b11, 0, 1, 32'h010, 64'h0123456789ABCDEF, 64'd0, 0);
    access(1, 2'b00, 0, 1, 32'h013, 64'h00000000000000A5, 64'd0, 2);
    access(1, 2'b11, 0, 0, 32'h014, 64'd0, 64'd0, 0);
    for (int i = 0; i < 80; i++) begin
      bit x;
      logic [1:0] sz;
      logic [31:0] a;
      x = 1'($urandom_range(1));
      sz = 2'($urandom_range(3));
      a = $urandom;
      if ($urandom_range(3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      access(x, sz, 1'($urandom_range(1)), 1'($urandom_range(1)), a,
             {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(10)) - 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
